// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK.
// Latency: INHIBIT_CYCLES + 1 cycles to request, then paced by the device clock (11 falling edges).
// Backpressure: tx_start is accepted only in IDLE; requests while busy or on the DONE/ERR cycle are dropped.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAITIDLE, S_DONE, S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic             clk_s1, clk_s2, clk_prev;
    logic             data_s1, data_s2;
    logic             clk_fall;
    logic [9:0]       shift;
    logic [3:0]       bit_idx;
    logic             data_drv;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout_hit;
    logic             to_active;

    // Sync stages reset to the idle-high line level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2data_i;
            data_s2  <= data_s1;
        end
    end

    assign clk_fall    = clk_prev & ~clk_s2;
    assign to_active   = (state == S_SEND) || (state == S_ACK) || (state == S_WAITIDLE);
    assign timeout_hit = (to_cnt == TO_LAST) && !clk_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (tx_start) state_nxt = S_INHIBIT;
            S_INHIBIT:  if (inh_cnt == INH_LAST) state_nxt = S_REQ;
            S_REQ:      state_nxt = S_SEND;
            S_SEND: begin
                if (clk_fall && bit_idx == 4'd9) state_nxt = S_ACK;
                else if (timeout_hit)            state_nxt = S_ERR;
            end
            S_ACK: begin
                if (clk_fall)         state_nxt = data_s2 ? S_ERR : S_WAITIDLE;
                else if (timeout_hit) state_nxt = S_ERR;
            end
            S_WAITIDLE: begin
                if (clk_s2 && data_s2) state_nxt = S_DONE;
                else if (timeout_hit)  state_nxt = S_ERR;
            end
            S_DONE:     state_nxt = S_IDLE;
            S_ERR:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift    <= '0;
            bit_idx  <= '0;
            data_drv <= 1'b0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    data_drv <= 1'b0;
                    if (tx_start) begin
                        shift   <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt <= '0;
                    end
                end
                S_INHIBIT: if (inh_cnt != INH_LAST) inh_cnt <= inh_cnt + INH_W'(1);
                S_REQ: begin
                    bit_idx  <= '0;
                    to_cnt   <= '0;
                    data_drv <= 1'b1;
                end
                S_SEND: begin
                    // Host changes data right after the device's falling edge; device samples on rising.
                    if (clk_fall) begin
                        data_drv <= ~shift[bit_idx];
                        bit_idx  <= bit_idx + 4'd1;
                    end
                end
                default: data_drv <= 1'b0;
            endcase

            if (to_active) begin
                if (clk_fall)              to_cnt <= '0;
                else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    always_comb begin
        tx_busy    = !(state == S_IDLE || state == S_DONE || state == S_ERR);
        rx_inhibit = tx_busy;
        tx_done    = (state == S_DONE);
        tx_error   = (state == S_ERR);
        ps2clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
        ps2data_oe = (state == S_REQ) || ((state == S_SEND) && data_drv);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int IC = 20;
    localparam int TC = 300;
    localparam int HP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error, rx_inhibit;
    logic       ps2clk_i, ps2data_i, ps2clk_oe, ps2data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    assign ps2clk_i  = ~ps2clk_oe & dev_clk;
    assign ps2data_i = ~ps2data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error), .rx_inhibit(rx_inhibit),
        .ps2clk_i(ps2clk_i), .ps2data_i(ps2data_i), .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done)  done_cnt++;
        if (tx_error) err_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        int         mode;
        logic [9:0] exp_bits;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device side: detect request-to-send, clock 11 pulses, sample bits on rising edges.
    // mode 1: pulse tx_start with 0x55 mid-frame; mode 2: assert reset during bit 4.
    task automatic dev_frame(input logic ack, input int mode, output logic [9:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", n < 2000, 1);
        if (n >= 2000) return;
        repeat (HP) @(negedge clk);
        for (int p = 1; p <= 11; p++) begin
            if (p == 11) begin
                if (ack) dev_data = 1'b0;
                repeat (2) @(negedge clk);
            end
            dev_clk = 1'b0;
            if (mode == 2 && p == 5) begin
                repeat (6) @(negedge clk);
                check("pre_rst_data_oe", ps2data_oe, 1);
                check("pre_rst_busy", tx_busy, 1);
                #2 rst = 1'b0;
                #1;
                check("rst_clk_oe", ps2clk_oe, 0);
                check("rst_data_oe", ps2data_oe, 0);
                check("rst_busy", tx_busy, 0);
                check("rst_inhibit", rx_inhibit, 0);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (mode == 1 && p == 3) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (HP - 1) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            dev_clk = 1'b1;
            if (p <= 10) bits[p-1] = ps2data_i;
            repeat (HP) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (tx_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 500, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [9:0] bits;
        int         d0, e0, n;

        vecs[0] = '{8'hED, 1'b1, 0, 10'h3ED, 1, 0};
        vecs[1] = '{8'h07, 1'b1, 0, 10'h207, 1, 0};
        vecs[2] = '{8'hA5, 1'b0, 0, 10'h3A5, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 0, 10'h300, 1, 0};
        vecs[4] = '{8'hED, 1'b1, 1, 10'h3ED, 1, 0};

        repeat (3) @(negedge clk);
        check("reset_busy", tx_busy, 0);
        check("reset_outputs", {tx_done, tx_error, rx_inhibit, ps2clk_oe, ps2data_oe}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", tx_busy, 0);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send(vecs[i].data);
            check($sformatf("v%0d_busy_on_accept", i), {tx_busy, rx_inhibit}, 2'b11);
            dev_frame(vecs[i].ack, vecs[i].mode, bits);
            wait_idle($sformatf("v%0d_busy_drop", i));
            check($sformatf("v%0d_bits", i), bits, vecs[i].exp_bits);
            check($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("v%0d_released", i), {ps2clk_oe, ps2data_oe, tx_busy}, 0);
        end

        // Inhibit length, start bit before clock release, then no device clock at all.
        e0 = err_cnt;
        send(8'h3C);
        n = 0;
        while (ps2clk_oe && !ps2data_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, IC);
        check("req_lines", {ps2clk_oe, ps2data_oe}, 2'b11);
        @(negedge clk);
        check("clk_released", {ps2clk_oe, ps2data_oe}, 2'b01);
        n = 0;
        while (!tx_error && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_len", n, TC);
        @(negedge clk);
        check("timeout_pulse_once", err_cnt - e0, 1);
        check("timeout_released", {tx_error, tx_busy, ps2clk_oe, ps2data_oe}, 0);

        // Reset mid-frame, then a clean send.
        send(8'h00);
        dev_frame(1'b1, 2, bits);
        repeat (5) @(negedge clk);
        check("post_rst_idle", {tx_busy, ps2clk_oe, ps2data_oe}, 0);
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hFF);
        dev_frame(1'b1, 0, bits);
        wait_idle("ff_busy_drop");
        check("ff_bits", bits, 10'h3FF);
        check("ff_done", done_cnt - d0, 1);
        check("ff_err", err_cnt - e0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
